// File: rtl/fwd_pkg.sv
// Shared types for the hazard / forwarding unit.
//   fwd_sel_e  : operand source select (RF, writeback, memory stage)
//   lu_state_e : load-use stall controller state
//   XLEN_DEF / RA_W_DEF : default datapath and register-address widths
package fwd_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } lu_state_e;
endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding: picks the newest producer of rs_e_i and muxes data.
//   rs_e_i        : E-stage source register address
//   rf_data_i     : operand captured from the register file at D/E
//   rd_m_i/regwrite_m_i/alu_m_i      : memory-stage producer
//   rd_w_i/regwrite_w_i/result_w_i   : writeback-stage producer
//   sel_o         : select (RF / W / M), src_o : forwarded operand
module operand_fwd_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs_e_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [RA_W-1:0] rd_m_i,
  input  logic            regwrite_m_i,
  input  logic [XLEN-1:0] alu_m_i,
  input  logic [RA_W-1:0] rd_w_i,
  input  logic            regwrite_w_i,
  input  logic [XLEN-1:0] result_w_i,
  output fwd_sel_e        sel_o,
  output logic [XLEN-1:0] src_o
);
  logic hit_m, hit_w;

  // x0 is hardwired zero, so it never forwards.
  assign hit_m = regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
  assign hit_w = regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

  // M is younger than W, so it wins when both match.
  always_comb begin
    sel_o = FWD_RF;
    if (hit_m)      sel_o = FWD_M;
    else if (hit_w) sel_o = FWD_W;
  end

  always_comb begin
    case (sel_o)
      FWD_M:   src_o = alu_m_i;
      FWD_W:   src_o = result_w_i;
      default: src_o = rf_data_i;
    endcase
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: D/E pipeline register, E-stage operand
// forwarding, load-use stall controller and branch flush.
//   D inputs  : RD1_D/RD2_D data, Rs1_D/Rs2_D/Rd_D addresses, RegWrite_D, MemRead_D
//   PCSrc_E   : taken branch in E -> flush D, abort any load-use stall
//   M/W inputs: Rd_M/RegWrite_M/ALUResult_M, Rd_W/RegWrite_W/Result_W
//   outputs   : SrcA_E/SrcB_E operands, ForwardA_E/ForwardB_E selects,
//               Stall_D (hold F/D), Flush_D (squash D)
// Optional build macro DECODE_BYPASS_EN: write-through of Result_W into the
// D/E capture when writeback targets a decode source register.
module hazard_forward_unit
  import fwd_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int LU_STALL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [RA_W-1:0] Rs1_D,
  input  logic [RA_W-1:0] Rs2_D,
  input  logic [RA_W-1:0] Rd_D,
  input  logic            RegWrite_D,
  input  logic            MemRead_D,
  input  logic            PCSrc_E,
  input  logic [RA_W-1:0] Rd_M,
  input  logic            RegWrite_M,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [RA_W-1:0] Rd_W,
  input  logic            RegWrite_W,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] SrcA_E,
  output logic [XLEN-1:0] SrcB_E,
  output logic [1:0]      ForwardA_E,
  output logic [1:0]      ForwardB_E,
  output logic            Stall_D,
  output logic            Flush_D
);
  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } de_t;

  localparam logic [1:0] LU_CNT_INIT = 2'(LU_STALL - 1);

  de_t             de_q, de_d;
  lu_state_e       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            lu_hit, stall, bubble;
  logic [XLEN-1:0] rd1_cap, rd2_cap;
  fwd_sel_e        sel_a, sel_b;

  // RegWrite_E is carried for downstream stages; nothing in this block reads it.
  logic unused_regwrite_e;
  assign unused_regwrite_e = de_q.regwrite;

  // Load in E whose destination feeds the instruction sitting in D.
  assign lu_hit = (state_q == ST_RUN) && de_q.memread && (de_q.rd != '0) &&
                  ((de_q.rd == Rs1_D) || (de_q.rd == Rs2_D));

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- FSM: next state. The detect cycle is the first stall cycle, so HOLD
  // covers the remaining LU_STALL-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (PCSrc_E) begin
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu_hit && (LU_STALL > 1)) begin
            state_d = ST_HOLD;
            cnt_d   = LU_CNT_INIT;
          end
        end
        ST_HOLD: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---- FSM: outputs. A taken branch squashes the stalled instruction anyway.
  always_comb begin
    stall   = rst_n && !PCSrc_E && (lu_hit || (state_q == ST_HOLD));
    Flush_D = rst_n && PCSrc_E;
  end
  assign Stall_D = stall;
  assign bubble  = PCSrc_E || stall;

  // ---- D/E capture
  always_comb begin
    rd1_cap = RD1_D;
    rd2_cap = RD2_D;
`ifdef DECODE_BYPASS_EN
    if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_D)) rd1_cap = Result_W;
    if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_D)) rd2_cap = Result_W;
`endif
  end

  always_comb begin
    de_d = '0;
    if (!bubble) begin
      de_d.rd1      = rd1_cap;
      de_d.rd2      = rd2_cap;
      de_d.rs1      = Rs1_D;
      de_d.rs2      = Rs2_D;
      de_d.rd       = Rd_D;
      de_d.regwrite = RegWrite_D;
      de_d.memread  = MemRead_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) de_q <= '0;
    else        de_q <= de_d;
  end

  // ---- E-stage forwarding
  operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
    .rs_e_i(de_q.rs1), .rf_data_i(de_q.rd1),
    .rd_m_i(Rd_M), .regwrite_m_i(RegWrite_M), .alu_m_i(ALUResult_M),
    .rd_w_i(Rd_W), .regwrite_w_i(RegWrite_W), .result_w_i(Result_W),
    .sel_o(sel_a), .src_o(SrcA_E)
  );

  operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
    .rs_e_i(de_q.rs2), .rf_data_i(de_q.rd2),
    .rd_m_i(Rd_M), .regwrite_m_i(RegWrite_M), .alu_m_i(ALUResult_M),
    .rd_w_i(Rd_W), .regwrite_w_i(RegWrite_W), .result_w_i(Result_W),
    .sel_o(sel_b), .src_o(SrcB_E)
  );

  assign ForwardA_E = sel_a;
  assign ForwardB_E = sel_b;
endmodule
